// File: rtl/eval_sched.sv
// eval_sched: round-robin scheduler that feeds one board at a time to the shared
// evaluate/board_attack engine pair, returns the tagged score and enforces a
// watchdog on the engine round-trip.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 256
`endif

module eval_sched #(
  parameter int NUM_REQ     = 4,
  parameter int EVAL_WIDTH  = 24,
  parameter int UCI_WIDTH   = 16,
  parameter int TIMEOUT     = 1023,
  parameter int BOARD_WIDTH = `BOARD_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*BOARD_WIDTH-1:0]      req_board,
  input  logic [NUM_REQ-1:0]                  req_white_to_move,
  input  logic [NUM_REQ*4-1:0]                req_castle_mask,
  input  logic [NUM_REQ*UCI_WIDTH-1:0]        req_uci,
  output logic [BOARD_WIDTH-1:0]              eng_board,
  output logic                                eng_white_to_move,
  output logic [3:0]                          eng_castle_mask,
  output logic [UCI_WIDTH-1:0]                eng_uci,
  output logic                                eng_board_valid,
  output logic                                eng_clear_eval,
  output logic                                eng_clear_attack,
  input  logic signed [EVAL_WIDTH-1:0]        eng_eval,
  input  logic                                eng_eval_valid,
  input  logic                                eng_pv_flag,
  input  logic                                eng_insufficient,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]          rsp_id,
  output logic signed [EVAL_WIDTH-1:0]        rsp_eval,
  output logic                                rsp_pv_flag,
  output logic                                rsp_insufficient,
  output logic                                rsp_timeout,
  output logic [31:0]                         eval_count
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, CLEAR, RESP} state_t;

  state_t                       state_q, state_d;
  logic [ID_W-1:0]              rr_ptr_q;
  logic [CNT_W-1:0]             wd_q;
  logic [BOARD_WIDTH-1:0]       eng_board_q;
  logic                         eng_wtm_q;
  logic [3:0]                   eng_castle_q;
  logic [UCI_WIDTH-1:0]         eng_uci_q;
  logic                         eng_bv_q, eng_clr_q, rsp_valid_q;
  logic [ID_W-1:0]              rsp_id_q;
  logic signed [EVAL_WIDTH-1:0] rsp_eval_q;
  logic                         rsp_pv_q, rsp_ins_q, rsp_to_q;
  logic [31:0]                  eval_count_q;

  logic [NUM_REQ-1:0]           grant;
  logic [ID_W-1:0]              grant_id;
  logic                         grant_vld;
  logic [ID_W:0]                scan;

  // Arbitration scan from rr_ptr upward (mod NUM_REQ) plus FSM next-state.
  always_comb begin
    state_d   = state_q;
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    scan      = '0;
    if (state_q == IDLE && reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
        if (scan >= (ID_W+1)'(NUM_REQ)) scan = scan - (ID_W+1)'(NUM_REQ);
        if (!grant_vld && req_valid[scan[ID_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_id  = scan[ID_W-1:0];
        end
      end
    end
    grant[grant_id] = grant_vld;
    case (state_q)
      IDLE:    if (grant_vld) state_d = RUN;
      RUN:     if (eng_eval_valid || wd_q == WD_LIMIT) state_d = CLEAR;
      CLEAR:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register; reset aborts any request in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request latch, watchdog, result capture and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q     <= '0;
      wd_q         <= '0;
      eng_board_q  <= '0;
      eng_wtm_q    <= 1'b0;
      eng_castle_q <= '0;
      eng_uci_q    <= '0;
      eng_bv_q     <= 1'b0;
      eng_clr_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_eval_q   <= '0;
      rsp_pv_q     <= 1'b0;
      rsp_ins_q    <= 1'b0;
      rsp_to_q     <= 1'b0;
      eval_count_q <= '0;
    end else begin
      eng_bv_q    <= (state_d == RUN);
      eng_clr_q   <= (state_d == CLEAR);
      rsp_valid_q <= (state_d == RESP);
      if (state_q == IDLE && grant_vld) begin
        eng_board_q  <= req_board[int'(grant_id)*BOARD_WIDTH +: BOARD_WIDTH];
        eng_wtm_q    <= req_white_to_move[grant_id];
        eng_castle_q <= req_castle_mask[int'(grant_id)*4 +: 4];
        eng_uci_q    <= req_uci[int'(grant_id)*UCI_WIDTH +: UCI_WIDTH];
        rsp_id_q     <= grant_id;
        rr_ptr_q     <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        wd_q         <= '0;
      end
      if (state_q == RUN) begin
        wd_q <= wd_q + 1'b1;
        // A valid result in the limit cycle takes precedence over the abort.
        if (eng_eval_valid) begin
          rsp_eval_q <= eng_eval;
          rsp_pv_q   <= eng_pv_flag;
          rsp_ins_q  <= eng_insufficient;
          rsp_to_q   <= 1'b0;
        end else if (wd_q == WD_LIMIT) begin
          rsp_eval_q <= '0;
          rsp_pv_q   <= 1'b0;
          rsp_ins_q  <= 1'b0;
          rsp_to_q   <= 1'b1;
        end
      end
      if (state_q == CLEAR && !rsp_to_q) eval_count_q <= eval_count_q + 32'd1;
    end
  end

  assign req_ready         = grant;
  assign eng_board         = eng_board_q;
  assign eng_white_to_move = eng_wtm_q;
  assign eng_castle_mask   = eng_castle_q;
  assign eng_uci           = eng_uci_q;
  assign eng_board_valid   = eng_bv_q;
  assign eng_clear_eval    = eng_clr_q;
  assign eng_clear_attack  = eng_clr_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_id            = rsp_id_q;
  assign rsp_eval          = rsp_eval_q;
  assign rsp_pv_flag       = rsp_pv_q;
  assign rsp_insufficient  = rsp_ins_q;
  assign rsp_timeout       = rsp_to_q;
  assign eval_count        = eval_count_q;

endmodule
